// File: rtl/simple_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : simple_spi_master
// Purpose  : SPI master, all CPOL/CPHA modes, selectable bit order, one word
//            per trigger inside a CS frame held while xfer_enable is high.
// Revision : 1.0 - initial release
// ============================================================================
module simple_spi_master #(
    parameter int WORDWIDTH                 = 8,
    parameter int PRESCALER_WIDTH           = 8,
    parameter int SYNCHRONIZE_MISO_FOR_CLKS = 2
) (
    input  logic                       system_clk,
    input  logic                       rst_n,
    input  logic [PRESCALER_WIDTH-1:0] clk_div,
    input  logic                       cpol,
    input  logic                       cpha,
    input  logic                       msb_first,
    input  logic                       xfer_enable,
    input  logic                       xfer_word_trigger,
    output logic                       xfer_word_completed,
    input  logic [WORDWIDTH-1:0]       data_tx,
    output logic [WORDWIDTH-1:0]       data_rx,
    output logic                       spi_cs,
    output logic                       spi_clk,
    input  logic                       spi_miso,
    output logic                       spi_mosi
);
    localparam int c_EDGE_W = $clog2(2 * WORDWIDTH + 1);
    localparam int c_SYNC   = SYNCHRONIZE_MISO_FOR_CLKS;
    localparam logic [c_EDGE_W-1:0] c_EDGES = c_EDGE_W'(2 * WORDWIDTH);
    localparam logic [c_EDGE_W-1:0] c_LAST  = c_EDGE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [PRESCALER_WIDTH-1:0] r_div;
    logic [PRESCALER_WIDTH-1:0] r_cnt;
    logic [c_EDGE_W-1:0]        r_edges;
    logic                       r_phase;
    logic                       r_cpol;
    logic                       r_cpha;
    logic                       r_msb;
    logic [WORDWIDTH-1:0]       r_tx;
    logic [WORDWIDTH-1:0]       r_rx_shift;
    logic [WORDWIDTH-1:0]       r_data_rx;
    logic                       r_mosi;
    logic                       r_done;
    logic [c_SYNC-1:0]          r_sync;
    logic [c_SYNC-1:0]          r_pipe;
    logic [c_SYNC-1:0]          w_pipe_rest;

    logic                       w_busy;
    logic                       w_start;
    logic                       w_toggle;
    logic                       w_sample_edge;
    logic                       w_shift_edge;
    logic                       w_capture;
    logic                       w_finish;
    logic                       w_complete;
    logic                       w_miso;
    logic                       w_next_bit;
    logic [WORDWIDTH-1:0]       w_tx_shifted;
    logic [WORDWIDTH-1:0]       w_rx_next;
    logic [PRESCALER_WIDTH-1:0] w_div_eff;

    assign w_busy        = (r_state == ST_BUSY);
    assign w_start       = (r_state == ST_READY) && xfer_enable && xfer_word_trigger;
    assign w_div_eff     = (clk_div == '0) ? PRESCALER_WIDTH'(1) : clk_div;
    assign w_toggle      = w_busy && (r_cnt == '0) && (r_edges != '0);
    // Sampling edge is leading (phase 0->1) for cpha=0, trailing for cpha=1.
    assign w_sample_edge = w_toggle && (r_phase == r_cpha);
    assign w_shift_edge  = w_toggle && (r_phase != r_cpha) && (r_cpha || (r_edges != c_LAST));
    assign w_miso        = r_sync[c_SYNC-1];
    // Each pending sample matures c_SYNC cycles after its edge, matching synchronizer latency.
    assign w_capture     = w_busy && r_pipe[c_SYNC-1];
    assign w_pipe_rest   = r_pipe << 1;
    assign w_finish      = w_busy && (r_edges == '0) && (w_pipe_rest == '0);
    assign w_complete    = w_finish && xfer_enable;
    assign w_next_bit    = r_msb ? r_tx[WORDWIDTH-1] : r_tx[0];
    assign w_tx_shifted  = r_msb ? (r_tx << 1) : (r_tx >> 1);
    assign w_rx_next     = !w_capture ? r_rx_shift :
                           r_msb ? {r_rx_shift[WORDWIDTH-2:0], w_miso}
                                 : {w_miso, r_rx_shift[WORDWIDTH-1:1]};

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!xfer_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_READY;
                ST_READY: if (xfer_word_trigger) w_state_next = ST_BUSY;
                ST_BUSY:  if (w_finish) w_state_next = ST_READY;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_cnt      <= '0;
            r_edges    <= '0;
            r_phase    <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_msb      <= 1'b0;
            r_tx       <= '0;
            r_rx_shift <= '0;
            r_data_rx  <= '0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_sync     <= '0;
            r_pipe     <= '0;
        end else begin
            r_sync <= (r_sync << 1) | c_SYNC'(spi_miso);
            r_done <= w_complete;
            if (w_complete) begin
                r_data_rx <= w_rx_next;
            end
            if (w_start) begin
                r_div   <= w_div_eff;
                r_cnt   <= w_div_eff - PRESCALER_WIDTH'(1);
                r_edges <= c_EDGES;
                r_phase <= 1'b0;
                r_cpol  <= cpol;
                r_cpha  <= cpha;
                r_msb   <= msb_first;
                r_pipe  <= '0;
                if (!cpha) begin
                    // cpha=0 presents the first bit before the first edge.
                    r_mosi <= msb_first ? data_tx[WORDWIDTH-1] : data_tx[0];
                    r_tx   <= msb_first ? (data_tx << 1) : (data_tx >> 1);
                end else begin
                    r_tx   <= data_tx;
                end
            end else if (w_busy && xfer_enable) begin
                r_pipe     <= (r_pipe << 1) | c_SYNC'(w_sample_edge);
                r_rx_shift <= w_rx_next;
                if (w_toggle) begin
                    r_phase <= ~r_phase;
                    r_edges <= r_edges - c_LAST;
                    r_cnt   <= r_div - PRESCALER_WIDTH'(1);
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - PRESCALER_WIDTH'(1);
                end
                if (w_shift_edge) begin
                    r_mosi <= w_next_bit;
                    r_tx   <= w_tx_shifted;
                end
            end else begin
                r_phase <= 1'b0;
                r_pipe  <= '0;
            end
        end
    end

    assign spi_cs              = (r_state != ST_IDLE);
    assign spi_clk             = (w_busy ? r_cpol : cpol) ^ r_phase;
    assign spi_mosi            = r_mosi;
    assign data_rx             = r_data_rx;
    assign xfer_word_completed = r_done;

endmodule
`default_nettype wire

// File: tb/tb_simple_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_spi_master
// Purpose  : Bench for simple_spi_master with a behavioural SPI slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_spi_master;
    localparam int W = 4;

    logic       system_clk = 1'b0;
    logic       rst_n;
    logic [3:0] clk_div;
    logic       cpol, cpha, msb_first;
    logic       xfer_enable, xfer_word_trigger;
    logic       xfer_word_completed;
    logic [3:0] data_tx;
    logic [3:0] data_rx;
    logic       spi_cs, spi_clk, spi_mosi;
    logic       spi_miso = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [3:0] slave_tx = 4'h0;
    logic [3:0] s_rx = 4'h0;
    logic       s_prev = 1'b0;
    int         s_next = 0;
    int         s_rx_cnt = 0;
    int         s_edges = 0;
    int         pulses = 0;
    int         cs_drops = 0;
    logic       frame_watch = 1'b0;
    logic [3:0] exp_rx = 4'h0;

    simple_spi_master #(
        .WORDWIDTH                 (W),
        .PRESCALER_WIDTH           (4),
        .SYNCHRONIZE_MISO_FOR_CLKS (3)
    ) dut (
        .system_clk          (system_clk),
        .rst_n               (rst_n),
        .clk_div             (clk_div),
        .cpol                (cpol),
        .cpha                (cpha),
        .msb_first           (msb_first),
        .xfer_enable         (xfer_enable),
        .xfer_word_trigger   (xfer_word_trigger),
        .xfer_word_completed (xfer_word_completed),
        .data_tx             (data_tx),
        .data_rx             (data_rx),
        .spi_cs              (spi_cs),
        .spi_clk             (spi_clk),
        .spi_miso            (spi_miso),
        .spi_mosi            (spi_mosi)
    );

    always #5 system_clk = ~system_clk;

    function automatic int idx_of(input int k, input logic msb);
        return msb ? (W - 1 - k) : k;
    endfunction

    // Slave: mode 0/2 present data before the first edge and sample on leading edges,
    // mode 1/3 shift on leading edges and sample on trailing edges.
    always @(posedge system_clk) begin
        s_prev <= spi_clk;
        if (xfer_word_trigger && spi_cs) begin
            s_edges  <= 0;
            s_rx_cnt <= 0;
            if (!cpha) begin
                spi_miso <= slave_tx[idx_of(0, msb_first)];
                s_next   <= 1;
            end else begin
                s_next   <= 0;
            end
        end else if (spi_cs && (spi_clk !== s_prev)) begin
            s_edges <= s_edges + 1;
            if ((spi_clk !== cpol) ^ cpha) begin
                if (s_rx_cnt < W) begin
                    s_rx[idx_of(s_rx_cnt, msb_first)] <= spi_mosi;
                    s_rx_cnt <= s_rx_cnt + 1;
                end
            end else if (s_next < W) begin
                spi_miso <= slave_tx[idx_of(s_next, msb_first)];
                s_next   <= s_next + 1;
            end
        end
    end

    always @(posedge system_clk) begin
        if (xfer_word_completed) pulses <= pulses + 1;
        if (frame_watch && !spi_cs) cs_drops <= cs_drops + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_word(input logic [3:0] tx, input logic [3:0] stx);
        int n;
        @(negedge system_clk);
        data_tx = tx;
        slave_tx = stx;
        xfer_word_trigger = 1'b1;
        @(negedge system_clk);
        xfer_word_trigger = 1'b0;
        check("cs_after_trigger", 32'(spi_cs), 32'(1));
        check("clk_after_trigger", 32'(spi_clk), 32'(cpol));
        n = 0;
        while (xfer_word_completed !== 1'b1 && n < 300) begin
            @(negedge system_clk);
            n++;
        end
        check("word_completed", 32'(xfer_word_completed), 32'(1));
        if (xfer_word_completed === 1'b1) begin
            exp_rx = stx;
            check("data_rx", 32'(data_rx), 32'(stx));
            check("slave_rx", 32'(s_rx), 32'(tx));
            check("spi_edges", 32'(s_edges), 32'(2 * W));
            check("clk_idle_at_done", 32'(spi_clk), 32'(cpol));
            check("cs_at_done", 32'(spi_cs), 32'(1));
            @(negedge system_clk);
            check("pulse_width", 32'(xfer_word_completed), 32'(0));
            @(negedge system_clk);
            check("data_rx_held", 32'(data_rx), 32'(stx));
        end
    endtask

    initial begin
        logic [3:0] pat_tx [4];
        logic [3:0] pat_rx [4];
        logic [2:0] mode;
        int p0;
        pat_tx = '{4'b0000, 4'b1111, 4'b0001, 4'b1110};
        pat_rx = '{4'b1111, 4'b0000, 4'b1000, 4'b1110};

        rst_n = 1'b0;
        clk_div = 4'd4;
        {cpol, cpha, msb_first} = 3'b001;
        xfer_enable = 1'b0;
        xfer_word_trigger = 1'b0;
        data_tx = 4'h0;
        repeat (3) @(negedge system_clk);
        check("reset_cs", 32'(spi_cs), 32'(0));
        check("reset_mosi", 32'(spi_mosi), 32'(0));
        check("reset_data_rx", 32'(data_rx), 32'(0));
        check("reset_done", 32'(xfer_word_completed), 32'(0));
        check("reset_clk", 32'(spi_clk), 32'(cpol));
        rst_n = 1'b1;
        @(negedge system_clk);
        check("cs_before_enable", 32'(spi_cs), 32'(0));

        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            {cpol, cpha, msb_first} = mode;
            xfer_enable = 1'b1;
            repeat (2) @(negedge system_clk);
            p0 = pulses;
            run_word(4'b0110, 4'b1010);
            for (int k = 0; k < 4; k++) run_word(pat_tx[k], pat_rx[k]);
            run_word(4'($urandom), 4'($urandom));
            run_word(4'($urandom), 4'($urandom));
            check("pulse_count_mode", 32'(pulses - p0), 32'(7));
            xfer_enable = 1'b0;
            @(negedge system_clk);
            check("cs_after_disable", 32'(spi_cs), 32'(0));
        end

        // Three words in one frame with a random mode and prescaler.
        {cpol, cpha, msb_first} = 3'($urandom);
        clk_div = 4'($urandom_range(7, 4));
        xfer_enable = 1'b1;
        repeat (2) @(negedge system_clk);
        p0 = pulses;
        frame_watch = 1'b1;
        run_word(4'b1010, 4'b0110);
        run_word(4'b0000, 4'b1111);
        run_word(4'b0101, 4'b1010);
        frame_watch = 1'b0;
        check("frame_pulses", 32'(pulses - p0), 32'(3));
        check("frame_cs_drops", 32'(cs_drops), 32'(0));
        xfer_enable = 1'b0;
        @(negedge system_clk);
        check("frame_cs_low", 32'(spi_cs), 32'(0));

        // Abort mid-word.
        clk_div = 4'd4;
        {cpol, cpha, msb_first} = 3'b100;
        xfer_enable = 1'b1;
        repeat (2) @(negedge system_clk);
        p0 = pulses;
        data_tx = 4'($urandom);
        slave_tx = 4'($urandom);
        xfer_word_trigger = 1'b1;
        @(negedge system_clk);
        xfer_word_trigger = 1'b0;
        repeat (6) @(negedge system_clk);
        xfer_enable = 1'b0;
        @(negedge system_clk);
        check("abort_cs", 32'(spi_cs), 32'(0));
        check("abort_clk", 32'(spi_clk), 32'(cpol));
        check("abort_done", 32'(xfer_word_completed), 32'(0));
        repeat (40) @(negedge system_clk);
        check("abort_no_pulse", 32'(pulses - p0), 32'(0));
        check("abort_data_rx", 32'(data_rx), 32'(exp_rx));

        // Recovery after abort.
        xfer_enable = 1'b1;
        repeat (2) @(negedge system_clk);
        run_word(4'($urandom), 4'($urandom));
        xfer_enable = 1'b0;
        @(negedge system_clk);

        // Reset mid-word.
        {cpol, cpha, msb_first} = 3'b111;
        xfer_enable = 1'b1;
        repeat (2) @(negedge system_clk);
        data_tx = 4'b1011;
        slave_tx = 4'b0111;
        xfer_word_trigger = 1'b1;
        @(negedge system_clk);
        xfer_word_trigger = 1'b0;
        repeat (5) @(negedge system_clk);
        rst_n = 1'b0;
        @(negedge system_clk);
        check("midreset_cs", 32'(spi_cs), 32'(0));
        check("midreset_clk", 32'(spi_clk), 32'(cpol));
        check("midreset_mosi", 32'(spi_mosi), 32'(0));
        check("midreset_data_rx", 32'(data_rx), 32'(0));
        check("midreset_done", 32'(xfer_word_completed), 32'(0));
        xfer_enable = 1'b0;
        @(negedge system_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge system_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
